// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 controller and its datapath:
// FSM states, opcodes, ALU operation codes and datapath mux selects.
package multicycle_ctrl_pkg;

   localparam int unsigned OPCODE_W = 7;
   localparam int unsigned FUNC3_W  = 3;
   localparam int unsigned STATE_W  = 4;
   localparam int unsigned ALUCTL_W = 3;
   localparam int unsigned SEL_W    = 2;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_LUI      = 4'd11,
      S_ILLEGAL  = 4'd12
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
   localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
   localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;

   localparam logic [ALUCTL_W-1:0] ALU_ADD   = 3'b000;
   localparam logic [ALUCTL_W-1:0] ALU_SUB   = 3'b001;
   localparam logic [ALUCTL_W-1:0] ALU_AND   = 3'b010;
   localparam logic [ALUCTL_W-1:0] ALU_OR    = 3'b011;
   localparam logic [ALUCTL_W-1:0] ALU_PASSB = 3'b100;
   localparam logic [ALUCTL_W-1:0] ALU_SLT   = 3'b101;
   localparam logic [ALUCTL_W-1:0] ALU_XOR   = 3'b110;
   localparam logic [ALUCTL_W-1:0] ALU_SRL   = 3'b111;

   localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
   localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
   localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

   localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
   localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
   localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

   localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

   // ALU operation class handed from the FSM to the ALU decoder
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNC  = 2'b10,
      ALUOP_PASSB = 2'b11
   } aluop_t;

   typedef struct packed {
      logic             pc_write;
      logic             adr_src;
      logic             ir_write;
      logic             mem_write;
      logic             reg_write;
      logic [SEL_W-1:0] result_src;
      logic [SEL_W-1:0] alu_src_a;
      logic [SEL_W-1:0] alu_src_b;
      logic             instr_done;
   } ctrl_t;

   // State that follows DECODE for a given opcode
   function automatic state_t decode_next(input logic [OPCODE_W-1:0] op);
      state_t nxt;
      case (op)
         OP_LOAD, OP_STORE: nxt = S_MEMADR;
         OP_RTYPE:          nxt = S_EXECR;
         OP_ITYPE:          nxt = S_EXECI;
         OP_BRANCH:         nxt = S_BRANCH;
         OP_JAL:            nxt = S_JAL;
         OP_LUI:            nxt = S_LUI;
         default:           nxt = S_ILLEGAL;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Maps ALU operation class plus func3/func7_5/opcode[5] onto the ALU control code.
module multicycle_ctrl_alu_decoder
   import multicycle_ctrl_pkg::*;
(
   input  aluop_t              alu_op,
   input  logic [FUNC3_W-1:0]  func3,
   input  logic                func7_5,
   input  logic                op5,
   output logic [ALUCTL_W-1:0] alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALUOP_ADD:   alu_control = ALU_ADD;
         ALUOP_SUB:   alu_control = ALU_SUB;
         ALUOP_PASSB: alu_control = ALU_PASSB;
         ALUOP_FUNC: begin
            case (func3)
               3'b000:  alu_control = (op5 && func7_5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b100:  alu_control = ALU_XOR;
               3'b101:  alu_control = ALU_SRL;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default:     alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32 datapath: sequences fetch, decode,
// execute and writeback, and drives every datapath select and write enable.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter bit USE_MEM_READY = 1'b1,
   parameter bit ILLEGAL_HALT  = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [FUNC3_W-1:0]  func3,
   input  logic                func7_5,
   input  logic                zero,
   input  logic                MemReady,
   output logic                PCWrite,
   output logic                AdrSrc,
   output logic                IRWrite,
   output logic                MemWrite,
   output logic                RegWrite,
   output logic [SEL_W-1:0]    ResultSrc,
   output logic [SEL_W-1:0]    ALUSrcA,
   output logic [SEL_W-1:0]    ALUSrcB,
   output logic [ALUCTL_W-1:0] ALUControl,
   output logic                InstrDone,
   output logic                Illegal,
   output logic [STATE_W-1:0]  State
);

   state_t state;
   state_t decoded;
   logic   illegal_q;
   logic   mem_ready;
   logic   taken;
   aluop_t alu_op;
   ctrl_t  ctrl;

   assign mem_ready = USE_MEM_READY ? MemReady : 1'b1;
   assign decoded   = decode_next(opcode);
   // func3[0] distinguishes bne from beq
   assign taken     = func3[0] ? ~zero : zero;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         case (state)
            S_FETCH:    if (mem_ready) state <= S_DECODE;
            S_DECODE: begin
               state <= decoded;
               if (decoded == S_ILLEGAL) illegal_q <= 1'b1;
            end
            S_MEMADR:   state <= opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
            S_MEMWB:    state <= S_FETCH;
            S_MEMWRITE: if (mem_ready) state <= S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_LUI: state <= S_ALUWB;
            S_ALUWB:    state <= S_FETCH;
            S_BRANCH:   state <= S_FETCH;
            S_ILLEGAL:  if (!ILLEGAL_HALT) state <= S_FETCH;
            default:    state <= S_FETCH;
         endcase
      end
   end

   // Moore decode of the current state; memory handshakes gate the enables
   always_comb begin
      ctrl   = '0;
      alu_op = ALUOP_ADD;
      case (state)
         S_FETCH: begin
            ctrl.adr_src    = 1'b0;
            ctrl.alu_src_a  = SRCA_PC;
            ctrl.alu_src_b  = SRCB_FOUR;
            ctrl.result_src = RES_ALURESULT;
            ctrl.ir_write   = mem_ready;
            ctrl.pc_write   = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_a = SRCA_OLDPC;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMADR: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMREAD: ctrl.adr_src = 1'b1;
         S_MEMWB: begin
            ctrl.result_src = RES_DATA;
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl.adr_src    = 1'b1;
            ctrl.mem_write  = 1'b1;
            ctrl.instr_done = mem_ready;
         end
         S_EXECR: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_RS2;
            alu_op         = ALUOP_FUNC;
         end
         S_EXECI: begin
            ctrl.alu_src_a = SRCA_RS1;
            ctrl.alu_src_b = SRCB_IMM;
            alu_op         = ALUOP_FUNC;
         end
         S_ALUWB: begin
            ctrl.result_src = RES_ALUOUT;
            ctrl.reg_write  = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a  = SRCA_RS1;
            ctrl.alu_src_b  = SRCB_RS2;
            ctrl.result_src = RES_ALUOUT;
            ctrl.pc_write   = taken;
            ctrl.instr_done = 1'b1;
            alu_op          = ALUOP_SUB;
         end
         S_JAL: begin
            ctrl.alu_src_a  = SRCA_OLDPC;
            ctrl.alu_src_b  = SRCB_FOUR;
            ctrl.result_src = RES_ALUOUT;
            ctrl.pc_write   = 1'b1;
         end
         S_LUI: begin
            ctrl.alu_src_b = SRCB_IMM;
            alu_op         = ALUOP_PASSB;
         end
         default: ctrl = '0;
      endcase
   end

   multicycle_ctrl_alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .func3       (func3),
      .func7_5     (func7_5),
      .op5         (opcode[5]),
      .alu_control (ALUControl)
   );

   // Reset suppresses every architectural write in the cycle it is seen
   assign PCWrite   = ctrl.pc_write   & ~rst;
   assign IRWrite   = ctrl.ir_write   & ~rst;
   assign MemWrite  = ctrl.mem_write  & ~rst;
   assign RegWrite  = ctrl.reg_write  & ~rst;
   assign InstrDone = ctrl.instr_done & ~rst;
   assign AdrSrc    = ctrl.adr_src;
   assign ResultSrc = ctrl.result_src;
   assign ALUSrcA   = ctrl.alu_src_a;
   assign ALUSrcB   = ctrl.alu_src_b;
   assign Illegal   = illegal_q & ~rst;
   assign State     = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and random instruction
// streams compared cycle by cycle against an instruction-level reference model.
module tb_multicycle_ctrl;
   import multicycle_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic [2:0] func3;
   logic       func7_5;
   logic       zero;
   logic       MemReady;
   logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, InstrDone, Illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ALUControl;
   logic [3:0] State;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt;
   logic model_ill = 1'b0;

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7_5(func7_5),
      .zero(zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUControl(ALUControl), .InstrDone(InstrDone), .Illegal(Illegal), .State(State)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
      end
   endtask

   // Expected mnemonic -> ALU code for a register/immediate arithmetic op
   function automatic logic [2:0] alu_ref(input logic is_r);
      case (func3)
         3'd0:    return (is_r && func7_5) ? 3'b001 : 3'b000;
         3'd2:    return 3'b101;
         3'd4:    return 3'b110;
         3'd5:    return 3'b111;
         3'd6:    return 3'b011;
         3'd7:    return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   // Expected output word {PCW,Adr,IRW,MemW,RegW,Res,SrcA,SrcB,ALU,Done,Ill,State}
   function automatic logic [19:0] exp_vec(input state_t ph, input logic mr);
      logic pcw = 0, adr = 0, irw = 0, memw = 0, regw = 0, done = 0;
      logic [1:0] rs = 0, sa = 0, sb = 0;
      logic [2:0] alu = 0;
      case (ph)
         S_FETCH:    begin sb = 2; rs = 2; irw = mr; pcw = mr; end
         S_DECODE:   begin sa = 1; sb = 1; end
         S_MEMADR:   begin sa = 2; sb = 1; end
         S_MEMREAD:  adr = 1;
         S_MEMWB:    begin rs = 1; regw = 1; done = 1; end
         S_MEMWRITE: begin adr = 1; memw = 1; done = mr; end
         S_EXECR:    begin sa = 2; sb = 0; alu = alu_ref(1'b1); end
         S_EXECI:    begin sa = 2; sb = 1; alu = alu_ref(1'b0); end
         S_ALUWB:    begin regw = 1; done = 1; end
         S_BRANCH:   begin sa = 2; alu = 3'b001; pcw = func3[0] ? ~zero : zero; done = 1; end
         S_JAL:      begin sa = 1; sb = 2; pcw = 1; end
         S_LUI:      begin sb = 1; alu = 3'b100; end
         default:    ;
      endcase
      if (rst) begin pcw = 0; irw = 0; memw = 0; regw = 0; done = 0; end
      return {pcw, adr, irw, memw, regw, rs, sa, sb, alu, done, model_ill & ~rst, 4'(ph)};
   endfunction

   // One cycle: drive MemReady, compare away from the edge, advance to next negedge
   task automatic cycle_check(input string name, input state_t ph, input logic mr);
      MemReady = mr;
      #1;
      check($sformatf("%s/%s", name, ph.name()),
            32'({PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                 ALUControl, InstrDone, Illegal, State}),
            32'(exp_vec(ph, mr)));
      if (InstrDone === 1'b1) done_cnt++;
      @(negedge clk);
   endtask

   // Memory-waiting phases stall 'stalls' cycles (-1: random) before MemReady
   task automatic do_phase(input string name, input state_t ph, input int stalls);
      int n;
      if (ph == S_FETCH || ph == S_MEMREAD || ph == S_MEMWRITE) begin
         n = (stalls < 0) ? int'($urandom_range(0, 2)) : stalls;
         for (int i = 0; i < n; i++) cycle_check(name, ph, 1'b0);
         cycle_check(name, ph, 1'b1);
      end else begin
         cycle_check(name, ph, 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                            input logic f75, input logic z, input int st_fetch, input int st_mem);
      state_t seq[$];
      opcode = op; func3 = f3; func7_5 = f75; zero = z;
      done_cnt = 0;
      case (op)
         7'b0000011: seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB};
         7'b0100011: seq = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE};
         7'b0110011: seq = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB};
         7'b0010011: seq = '{S_FETCH, S_DECODE, S_EXECI, S_ALUWB};
         7'b1100011: seq = '{S_FETCH, S_DECODE, S_BRANCH};
         7'b1101111: seq = '{S_FETCH, S_DECODE, S_JAL, S_ALUWB};
         default:    seq = '{S_FETCH, S_DECODE, S_LUI, S_ALUWB};
      endcase
      foreach (seq[i]) do_phase(name, seq[i], (i == 0) ? st_fetch : st_mem);
      check({name, "/retire_count"}, 32'(done_cnt), 32'd1);
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      for (int i = 0; i < cycles; i++) cycle_check("reset", S_FETCH, 1'b1);
      rst = 1'b0;
   endtask

   logic [6:0] legal_ops [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                 7'b1100011, 7'b1101111, 7'b0110111};

   initial begin
      rst = 1'b1; opcode = 7'b0110011; func3 = 0; func7_5 = 0; zero = 0; MemReady = 1'b1;
      @(negedge clk);
      do_reset(3);

      run_instr("add",  7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
      run_instr("sub",  7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);
      run_instr("srl",  7'b0110011, 3'b101, 1'b0, 1'b0, 0, 0);
      run_instr("slt",  7'b0110011, 3'b010, 1'b0, 1'b0, 0, 0);
      run_instr("addi", 7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0);
      run_instr("lw",   7'b0000011, 3'b010, 1'b0, 1'b0, 0, 2);
      run_instr("sw",   7'b0100011, 3'b010, 1'b0, 1'b0, 0, 1);
      run_instr("beq1", 7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);
      run_instr("bne1", 7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0);
      run_instr("bne0", 7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0);
      run_instr("jal",  7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);
      run_instr("lui",  7'b0110111, 3'b000, 1'b0, 1'b0, 0, 0);
      run_instr("fstall", 7'b0110011, 3'b110, 1'b0, 1'b0, 2, 0);

      for (int k = 0; k < 40; k++)
         run_instr($sformatf("rnd%0d", k), legal_ops[$urandom_range(0, 6)],
                   3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), -1, -1);

      // Unknown opcode parks in ILLEGAL with the sticky flag raised
      opcode = 7'h7F;
      do_phase("illegal", S_FETCH, 0);
      do_phase("illegal", S_DECODE, 0);
      model_ill = 1'b1;
      for (int i = 0; i < 10; i++) do_phase("illegal", S_ILLEGAL, 0);
      rst = 1'b1;
      cycle_check("illegal_rst", S_ILLEGAL, 1'b1);
      model_ill = 1'b0;
      rst = 1'b0;
      run_instr("post_illegal", 7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0);

      // Reset landing in MEMWRITE abandons the store without writing
      opcode = 7'b0100011; func3 = 3'b010;
      do_phase("sw_rst", S_FETCH, 0);
      do_phase("sw_rst", S_DECODE, 0);
      do_phase("sw_rst", S_MEMADR, 0);
      rst = 1'b1;
      cycle_check("sw_rst", S_MEMWRITE, 1'b0);
      rst = 1'b0;
      run_instr("post_sw_rst", 7'b0110011, 3'b100, 1'b0, 1'b0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
